serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Multi-cycle, parametrised bit-serial adder/subtractor. It processes DIGIT bits per clock, LSB first, through a registered carry chain, so a WIDTH-bit add uses one DIGIT-wide full-adder slice over time.
It is the sequential successor to the team's 1-bit combinational full adder. It is used where area matters more than latency.
A start/busy/done handshake connects it to a controller.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥1.
DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise).

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request a new operation; sampled only when not busy.
sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin); captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
cin  input  1  carry-in (add) / borrow-in (sub); captured with start.
busy  output  1  high while digits are being processed.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  result register.
cout  output  1  final carry-out; in subtract mode, 1 = no borrow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers and carry cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE. N = WIDTH/DIGIT.
- IDLE or DONE with start=1 at edge E0:
  - capture a into the A shift register;
  - capture b, or ~b if sub=1, into the B shift register;
  - initial carry = cin XOR sub;
  - digit counter = 0; go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - low DIGIT bits of A and B plus carry → DIGIT-bit sum and new carry, rippled through the slice combinationally;
  - sum digit shifts into the result shift register from the MSB end;
  - A/B shift right by DIGIT; counter increments.
- On the N-th RUN edge (EN): go to DONE; copy the result shift register to sum and the final carry to cout.
- Timing: done=1 for exactly the one cycle following EN, i.e. done is first observed N cycles after start is sampled.
  - busy=1 from the cycle after E0 through the cycle ending at EN; busy=0 in IDLE and DONE.
- sum/cout hold the last result until the next completion; they do not change during RUN.
- start while busy=1 is ignored: no queueing, operands unaffected.
- start during the DONE cycle is accepted: back-to-back throughput is N+1 cycles per operation.
- Arithmetic is modulo 2^WIDTH; carry beyond the MSB appears only on cout.

Optional Feature:
SERIAL_ADDER_OVF_EN:
- Defined: adds output port ovf (1 bit), signed two's-complement overflow. Computed as the carry into the MSB XOR the carry out of the MSB on the final digit. Registered with sum at EN, held until the next completion, reset to 0.
- Undefined: port absent and no overflow logic is built; all other behaviour is identical.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, sub=0, cin=0, start for 1 cycle → busy for 8 cycles; done pulses 8 cycles after start; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0, add → sum=0x00, cout=1. Then a=0x00, b=0x01, sub=1, cin=0 → sum=0xFF, cout=0 (borrow). Then a=0x10, b=0x01, sub=1 → sum=0x0F, cout=1.
3. Start 0x01+0x02; assert start with a=0xAA, b=0x55 at cycle 3 of RUN → ignored; result 0x03, single done pulse. Start held high through DONE → second operation begins immediately; next done 9 cycles after the first.
4. Pull rst_n low at cycle 4 of RUN, asynchronously mid-cycle → busy, done, sum, cout go to 0 immediately; no done pulse; a fresh start after release gives the correct result.
5. WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=1 → done 4 cycles after start; sum=0x0001, cout=1.
6. With SERIAL_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 → sum=0x80, ovf=1. Then 0x80-0x01 (sub) → sum=0x7F, ovf=1. Then 0x05+0x03 → ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: DIGIT bits per cycle, LSB first, through a registered carry.
// Optional signed-overflow output is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;

  // One DIGIT-wide ripple slice; c[DIGIT-1] is the carry into the digit MSB.
  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
    end
    res_next = (res_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= c[DIGIT];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_next;
            cout  <= c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance.
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic        sub_in = 1'b0;
  logic        cin_in = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        busy8, done8, cout8, busy16, done16, cout16;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic        ovf8, ovf16;

  logic        use_wide = 1'b0;
  logic        sel_busy, sel_done, sel_cout, sel_ovf;
  logic [15:0] sel_sum;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub_in),
    .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  always_comb begin
    sel_busy = use_wide ? busy16 : busy8;
    sel_done = use_wide ? done16 : done8;
    sel_cout = use_wide ? cout16 : cout8;
    sel_ovf  = use_wide ? ovf16 : ovf8;
    sel_sum  = use_wide ? sum16 : {8'h00, sum8};
  end

  typedef struct {
    bit          wide;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation, then check latency, busy length, result stability and the result itself.
  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    int busy_n;
    bit stable;
    bit got;
    logic [15:0] prev_sum;
    int exp_lat;
    exp_lat = v.wide ? 4 : 8;
    @(negedge clk);
    use_wide = v.wide;
    a_in = v.a; b_in = v.b; sub_in = v.sub; cin_in = v.cin;
    if (v.wide) start16 = 1'b1; else start8 = 1'b1;
    #1 prev_sum = sel_sum;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    lat = 0; busy_n = 0; stable = 1'b1; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (sel_done) got = 1'b1;
      else begin
        if (sel_busy) busy_n++;
        if (sel_sum !== prev_sum) stable = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    checkOutput($sformatf("vec%0d latency", idx), lat, exp_lat);
    checkOutput($sformatf("vec%0d busy cycles", idx), busy_n, exp_lat);
    checkOutput($sformatf("vec%0d sum stable in RUN", idx), {31'd0, stable}, 32'd1);
    checkOutput($sformatf("vec%0d sum", idx), {16'd0, sel_sum}, {16'd0, v.exp_sum});
    checkOutput($sformatf("vec%0d cout", idx), {31'd0, sel_cout}, {31'd0, v.exp_cout});
    checkOutput($sformatf("vec%0d busy at done", idx), {31'd0, sel_busy}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput($sformatf("vec%0d ovf", idx), {31'd0, sel_ovf}, {31'd0, v.exp_ovf});
`endif
    @(posedge clk); #1;
    checkOutput($sformatf("vec%0d done one cycle", idx), {31'd0, sel_done}, 32'd0);
  endtask

  initial begin
    int lat;
    int dones;
    vecs[0]  = '{1'b0, 16'h005A, 16'h003C, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0012, 16'h0034, 1'b0, 1'b1, 16'h0047, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0050, 16'h0020, 1'b1, 1'b1, 16'h002F, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'h00C8, 16'h0064, 1'b0, 1'b0, 16'h002C, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    #12;
    checkOutput("reset busy8", {31'd0, busy8}, 32'd0);
    checkOutput("reset done8", {31'd0, done8}, 32'd0);
    checkOutput("reset sum8", {24'd0, sum8}, 32'd0);
    checkOutput("reset cout8", {31'd0, cout8}, 32'd0);
    checkOutput("reset sum16", {16'd0, sum16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Start while busy is ignored; start held through DONE chains a second op.
    use_wide = 1'b0;
    @(negedge clk);
    a_in = 16'h0001; b_in = 16'h0002; sub_in = 1'b0; cin_in = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a_in = 16'h00AA; b_in = 16'h0055; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 4;
    for (int k = 0; k < 40 && !done8; k++) begin @(posedge clk); #1; lat++; end
    checkOutput("busy-start latency", lat, 8);
    checkOutput("busy-start sum", {24'd0, sum8}, 32'h03);
    a_in = 16'h0020; b_in = 16'h0022; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("back-to-back busy", {31'd0, busy8}, 32'd1);
    checkOutput("back-to-back done low", {31'd0, done8}, 32'd0);
    lat = 1;
    for (int k = 0; k < 40 && !done8; k++) begin @(posedge clk); #1; lat++; end
    checkOutput("back-to-back spacing", lat, 9);
    checkOutput("back-to-back sum", {24'd0, sum8}, 32'h42);

    // Asynchronous reset mid-RUN aborts with no done pulse.
    @(negedge clk);
    a_in = 16'h0033; b_in = 16'h0011; sub_in = 1'b0; cin_in = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {31'd0, busy8}, 32'd0);
    checkOutput("async reset done", {31'd0, done8}, 32'd0);
    checkOutput("async reset sum", {24'd0, sum8}, 32'd0);
    checkOutput("async reset cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) dones++; end
    checkOutput("no done after abort", dones, 0);
    applyStimulus('{1'b0, 16'h0033, 16'h0011, 1'b0, 1'b0, 16'h0044, 1'b0, 1'b0}, 99);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
